// File: rtl/axi_write_arbiter_if.sv
// Bundle of request, downstream-handshake and grant/enable signals for axi_write_arbiter.
// "slave" is the arbiter's view; "master" is the requester/downstream side that drives it.
interface axi_write_arbiter_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 req0_awvalid;
  logic [LEN_WIDTH-1:0] req0_awlen;
  logic                 req1_awvalid;
  logic [LEN_WIDTH-1:0] req1_awlen;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 grant_valid;
  logic                 grant_sel;
  logic                 aw_enable;
  logic                 w_enable;
  logic                 b_enable;
  logic                 w_last;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 burst_done;
  // Debug view of the FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP).
  logic [1:0]           dbg_state;

  // Handshake semantics: aw_hs/w_hs/b_hs are single-cycle "transfer happened" strobes
  // (valid && ready already combined downstream); each is only honoured while the
  // matching *_enable output is high, and is ignored otherwise.
  modport slave (
    input  req0_awvalid, req0_awlen, req1_awvalid, req1_awlen, aw_hs, w_hs, b_hs,
    output grant_valid, grant_sel, aw_enable, w_enable, b_enable, w_last,
           beats_left, burst_done, dbg_state
  );

  modport master (
    output req0_awvalid, req0_awlen, req1_awvalid, req1_awlen, aw_hs, w_hs, b_hs,
    input  grant_valid, grant_sel, aw_enable, w_enable, b_enable, w_last,
           beats_left, burst_done, dbg_state
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-requester AXI write-path arbiter: owns one burst at a time through ADDR/DATA/RESP.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin on contested requests; default is fixed priority to requester 0.
module axi_write_arbiter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  axi_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 grant_sel_q, grant_sel_d;
  logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;
  logic                 burst_done_q, burst_done_d;
  logic                 winner;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic                 last_owner_q, last_owner_d;

  // Contested: hand the path to whoever did not own it last; otherwise the lone requester.
  assign winner = (bus.req0_awvalid && bus.req1_awvalid) ? ~last_owner_q : ~bus.req0_awvalid;
`else
  assign winner = ~bus.req0_awvalid;
`endif

  always_comb begin
    state_d      = state_q;
    grant_sel_d  = grant_sel_q;
    beats_left_d = beats_left_q;
    burst_done_d = 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0_awvalid || bus.req1_awvalid) begin
          state_d      = ADDR;
          grant_sel_d  = winner;
          beats_left_d = winner ? bus.req1_awlen : bus.req0_awlen;
        end
      end
      ADDR: begin
        if (bus.aw_hs) state_d = DATA;
      end
      DATA: begin
        // beats_left counts remaining beats minus one, so all-ones gives 2^LEN_WIDTH beats.
        if (bus.w_hs) begin
          if (beats_left_q == '0) state_d = RESP;
          else                    beats_left_d = beats_left_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.b_hs) begin
          state_d      = IDLE;
          burst_done_d = 1'b1;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          last_owner_d = grant_sel_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_sel_q  <= 1'b0;
      beats_left_q <= '0;
      burst_done_q <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_sel_q  <= grant_sel_d;
      beats_left_q <= beats_left_d;
      burst_done_q <= burst_done_d;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign bus.grant_valid = (state_q != IDLE);
  assign bus.grant_sel   = grant_sel_q;
  assign bus.aw_enable   = (state_q == ADDR);
  assign bus.w_enable    = (state_q == DATA);
  assign bus.b_enable    = (state_q == RESP);
  assign bus.w_last      = (state_q == DATA) && (beats_left_q == '0);
  assign bus.beats_left  = beats_left_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of one burst in flight.
module tb_axi_write_arbiter;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  axi_write_arbiter_if #(.LEN_WIDTH(LW)) bus ();

  axi_write_arbiter #(.LEN_WIDTH(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run = 0;
  int failed    = 0;

  // ---------------- reference model ----------------
  // One burst at a time: who owns it, how many beats it has, how many have moved,
  // and which phase (0 address, 1 data, 2 response) it is in.
  bit m_busy;
  int m_phase;
  bit m_owner;
  int m_total;
  int m_sent;
  bit m_done;
  bit m_last;

  logic [0:0] exp_q[$];

  task automatic model_reset();
    m_busy  = 0;
    m_phase = 0;
    m_owner = 0;
    m_total = 0;
    m_sent  = 0;
    m_done  = 0;
    m_last  = 1;
  endtask

  task automatic model_tick();
    m_done = 0;
    if (!m_busy) begin
      if (bus.req0_awvalid || bus.req1_awvalid) begin
        if (bus.req0_awvalid && bus.req1_awvalid) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
          m_owner = ~m_last;
`else
          m_owner = 1'b0;
`endif
        end else begin
          m_owner = bus.req0_awvalid ? 1'b0 : 1'b1;
        end
        m_total = (m_owner ? int'(bus.req1_awlen) : int'(bus.req0_awlen)) + 1;
        m_sent  = 0;
        m_phase = 0;
        m_busy  = 1;
      end
    end else begin
      case (m_phase)
        0: if (bus.aw_hs) m_phase = 1;
        1: if (bus.w_hs) begin
             m_sent++;
             if (m_sent == m_total) m_phase = 2;
           end
        default: if (bus.b_hs) begin
             m_busy = 0;
             m_last = m_owner;
             m_done = 1;
           end
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_bl;
    if (m_busy && m_phase == 0)      exp_bl = m_total - 1;
    else if (m_busy && m_phase == 1) exp_bl = m_total - 1 - m_sent;
    else                             exp_bl = 0;
    chk({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(m_busy));
    chk({tag, ".grant_sel"},   32'(bus.grant_sel),   32'(m_owner));
    chk({tag, ".aw_enable"},   32'(bus.aw_enable),   32'(m_busy && m_phase == 0));
    chk({tag, ".w_enable"},    32'(bus.w_enable),    32'(m_busy && m_phase == 1));
    chk({tag, ".b_enable"},    32'(bus.b_enable),    32'(m_busy && m_phase == 2));
    chk({tag, ".w_last"},      32'(bus.w_last),      32'(m_busy && m_phase == 1 && (m_total - m_sent) == 1));
    chk({tag, ".beats_left"},  32'(bus.beats_left),  32'(exp_bl));
    chk({tag, ".burst_done"},  32'(bus.burst_done),  32'(m_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v0, input int l0, input bit v1, input int l1,
                       input bit aw, input bit w, input bit b);
    bus.req0_awvalid = v0;
    bus.req0_awlen   = LW'(l0);
    bus.req1_awvalid = v1;
    bus.req1_awlen   = LW'(l1);
    bus.aw_hs        = aw;
    bus.w_hs         = w;
    bus.b_hs         = b;
  endtask

  // Inputs are held across the edge; outputs are sampled 1 time unit after it.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_tick();
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    int cyc;
    bit was_busy;

    // Reset: asynchronous, outputs must clear without a clock edge.
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) tick("reset_hold");
    reset_n = 1'b1;

    // req0 alone, awlen=3: grant next cycle, 4 beats, w_last on the 4th, done pulse.
    tick("idle");
    drive(1, 3, 0, 0, 0, 0, 0);
    tick("s1_grant");
    drive(0, 0, 0, 0, 1, 0, 0);
    tick("s1_addr");
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick("s1_beat");
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("s1_resp");
    chk("s1_done_pulse", 32'(bus.burst_done), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("s1_after");
    chk("s1_done_cleared", 32'(bus.burst_done), 32'd0);

    // req1 alone, awlen=0: single beat, w_last immediately, grant_sel=1.
    drive(0, 0, 1, 0, 0, 0, 0);
    tick("s3_grant");
    drive(0, 0, 0, 0, 1, 0, 0);
    tick("s3_addr");
    chk("s3_wlast_first", 32'(bus.w_last), 32'd1);
    chk("s3_sel", 32'(bus.grant_sel), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    tick("s3_beat");
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("s3_resp");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("s3_idle");

    // Both requesting, all strobes held high (aw_hs+w_hs together in ADDR counts once).
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1, 0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      was_busy = m_busy;
      tick("s2_contest");
      if (m_busy && !was_busy && exp_q.size() > 0)
        chk("s2_grant_order", 32'(bus.grant_sel), 32'(exp_q.pop_front()));
    end
    chk("s2_all_grants_seen", 32'(exp_q.size()), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    while (m_busy) tick("s2_drain_noreq");
    tick("s2_idle");

    // awlen=255 with random gaps and stray aw/b strobes during DATA.
    drive(1, 255, 0, 0, 0, 0, 0);
    tick("s4_grant");
    drive(0, 0, 0, 0, 0, 1, 1);
    tick("s4_addr_ignore");
    drive(0, 0, 0, 0, 1, 0, 0);
    tick("s4_addr");
    beats = 0;
    cyc   = 0;
    while (!(m_busy && m_phase == 2) && cyc < 3000) begin
      drive(0, 0, 0, 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 1)));
      if (bus.w_hs) beats++;
      tick("s4_data");
      cyc++;
    end
    chk("s4_reached_resp", 32'(m_busy && m_phase == 2), 32'd1);
    chk("s4_beat_count", 32'(beats), 32'd256);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("s4_resp");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("s4_idle");

    // Reset in DATA with beats_left=5: abandon burst, no done pulse, req0 wins next contest.
    drive(0, 0, 1, 7, 0, 0, 0);
    tick("s6_grant");
    drive(0, 0, 0, 0, 1, 0, 0);
    tick("s6_addr");
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick("s6_beat");
    chk("s6_beats_left", 32'(bus.beats_left), 32'd5);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("s6_async_reset");
    tick("s6_reset_hold");
    reset_n = 1'b1;
    tick("s6_no_done");
    drive(1, 0, 1, 0, 0, 0, 0);
    tick("s6_contest");
    chk("s6_req0_wins", 32'(bus.grant_sel), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    tick("s6_addr2");
    drive(0, 0, 0, 0, 0, 1, 0);
    tick("s6_beat2");
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("s6_resp2");

    // Randomized traffic: requests, lengths and strobes all independent.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 6),
            1'($urandom_range(0, 1)), $urandom_range(0, 6),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have parameter: LEN_WIDTH, 8, width of burst length fields (AXI awlen: transfers minus 1).
REQ-002 SHALL have ports (name direction width meaning):
- clk  input  1  sole clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_awvalid  input  1  requester 0 write-address valid
- req0_awlen  input  LEN_WIDTH  requester 0 burst length minus 1
- req1_awvalid  input  1  requester 1 write-address valid
- req1_awlen  input  LEN_WIDTH  requester 1 burst length minus 1
- aw_hs  input  1  downstream address handshake (awvalid && awready)
- w_hs  input  1  downstream data-beat handshake (wvalid && wready)
- b_hs  input  1  downstream response handshake (bvalid && bready)
- grant_valid  output  1  a requester owns the write path
- grant_sel  output  1  owning requester index
- aw_enable  output  1  address channel of owner forwarded
- w_enable  output  1  data channel of owner forwarded
- b_enable  output  1  response channel of owner forwarded
- w_last  output  1  current beat is final beat of burst
- beats_left  output  LEN_WIDTH  beats remaining minus 1
- burst_done  output  1  one-cycle pulse after burst completes

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, DATA, RESP, all outputs decoded from registered state.
REQ-004 IDLE: if either awvalid high, SHALL select winner per REQ-011/012, latch grant_sel and winner's awlen into beats_left, go to ADDR; grant_valid high the next cycle (1-cycle latency).
REQ-005 IDLE with no request SHALL remain in IDLE.
REQ-006 ADDR: aw_enable=1; on aw_hs SHALL go to DATA.
REQ-007 DATA: w_enable=1; on w_hs with beats_left!=0 SHALL decrement beats_left; on w_hs with beats_left==0 SHALL go to RESP.
REQ-008 w_last SHALL equal (state==DATA && beats_left==0).
REQ-009 RESP: b_enable=1; on b_hs SHALL go to IDLE, record grant_sel as last owner, assert burst_done for exactly the following cycle.
REQ-010 grant_valid SHALL be 1 in ADDR, DATA, RESP; grant_sel SHALL stay constant from ADDR entry until IDLE re-entry, regardless of requester awvalid changes.
REQ-011 Simultaneous requests SHALL be resolved per Configuration REQ-016/017.
REQ-012 Single request SHALL always be granted irrespective of last owner.
REQ-013 aw_hs, w_hs, b_hs SHALL be ignored in any state other than ADDR, DATA, RESP respectively; aw_hs and w_hs in the same ADDR cycle SHALL count only aw_hs.
REQ-014 awlen=0 SHALL yield a single-beat burst (w_last high on first DATA cycle); awlen=all-ones SHALL yield 2^LEN_WIDTH beats with no wrap of beats_left.

Reset
REQ-015 While reset_n low, asynchronously: state=IDLE, grant_sel=0, beats_left=0, burst_done=0, last owner=1 (requester 0 wins first contested arbitration); all enables, w_last, grant_valid=0. Reset mid-burst SHALL abandon the burst with no burst_done pulse.

Configuration
REQ-016 Macro AXI_ARB_ROUND_ROBIN_EN defined: contested arbitration SHALL grant the requester that is not the last owner.
REQ-017 Macro undefined: contested arbitration SHALL always grant requester 0 (fixed priority); last-owner register may be omitted.

Verification
REQ-018 Scenarios the bench SHALL cover:
- Reset release, req0 awvalid, awlen=3 -> grant_valid next cycle, grant_sel=0; after aw_hs, 4 w_hs, w_last on 4th; b_hs -> burst_done pulse one cycle, then IDLE.
- Both requesting continuously, awlen=0, RR_EN defined -> grants alternate 0,1,0,1; undefined -> always 0.
- req1 only, awlen=0 -> single DATA beat, w_last high immediately, grant_sel=1.
- awlen=255 -> exactly 256 w_hs before RESP; w_hs stalls (gaps) do not decrement beats_left.
- w_hs/b_hs pulses during ADDR -> ignored, beats_left unchanged; aw_hs during DATA ignored.
- reset_n low in DATA with beats_left=5 -> immediate IDLE, all outputs 0, no burst_done; next contested grant to requester 0.
